// File: rtl/ipml_fifo_fwft_rd_stage_pkg.sv
// Shared constants and parameter-legality helpers for the FWFT read stage.
package ipml_fifo_fwft_rd_stage_pkg;

    // Width of buf_level and of the internal occupancy counters (0..4 fits).
    localparam int LEVEL_W = 3;

    // Memory read latency must be 1..3 cycles.
    function automatic bit rd_latency_ok(input int lat);
        return (lat >= 1) && (lat <= 3);
    endfunction

    // Buffer must hold every in-flight word plus the one being presented.
    function automatic bit buf_depth_ok(input int depth, input int lat);
        return (depth >= 2) && (depth <= 4) && (depth >= lat + 1);
    endfunction

endpackage

// File: rtl/ipml_fifo_outbuf_ring.sv
// Small register ring buffer: one write and one read port, level and flags.
// Reads of an empty ring are ignored; writes are trusted to fit because the
// caller only issues memory reads when room is guaranteed.
module ipml_fifo_outbuf_ring
    import ipml_fifo_fwft_rd_stage_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_data,
    input  logic               rd_en,
    output logic [W-1:0]       rd_data,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_ok;

    assign rd_ok   = rd_en && !empty;
    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ipml_fifo_fwft_rd_stage.sv
// FWFT read stage: issues FIFO reads while the output buffer has room for
// everything already requested, captures returning words after the fixed
// memory latency and presents the buffer head as a valid/ready stream.
module ipml_fifo_fwft_rd_stage
    import ipml_fifo_fwft_rd_stage_pkg::*;
#(
    parameter int c_RD_DATA_WIDTH = 8,
    parameter int c_RD_LATENCY    = 1,
    parameter int c_BUF_DEPTH     = 2
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       fifo_rempty,
    output logic                       fifo_rd_en,
    input  logic [c_RD_DATA_WIDTH-1:0] ram_rdata,
    output logic [c_RD_DATA_WIDTH-1:0] dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [LEVEL_W-1:0]         buf_level
);

    if (!rd_latency_ok(c_RD_LATENCY)) begin : g_bad_latency
        $error("c_RD_LATENCY must be in 1..3");
    end
    if (!buf_depth_ok(c_BUF_DEPTH, c_RD_LATENCY)) begin : g_bad_depth
        $error("c_BUF_DEPTH must be in 2..4 and at least c_RD_LATENCY+1");
    end

    logic [c_RD_LATENCY-1:0] lat_pipe;
    logic                    pop;
    logic                    capture;
    logic                    deq;
    logic                    buf_empty;
    logic                    buf_full_unused;
    logic [LEVEL_W-1:0]      inflight_cnt;
    logic [LEVEL_W:0]        demand;

    assign pop     = fifo_rd_en && !fifo_rempty;
    assign capture = lat_pipe[c_RD_LATENCY-1];
    assign deq     = dout_valid && dout_ready;

    // Words requested but not yet written into the buffer.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < c_RD_LATENCY; i++)
            inflight_cnt = inflight_cnt + LEVEL_W'(lat_pipe[i]);
    end

    // Occupancy after this cycle if no new read were issued; a read is only
    // allowed when that leaves a free slot, so captures can never overflow.
    assign demand     = {1'b0, buf_level} + {1'b0, inflight_cnt} - (LEVEL_W + 1)'(deq);
    assign fifo_rd_en = !rrst && !fifo_rempty && (demand < (LEVEL_W + 1)'(c_BUF_DEPTH));

    // Pop valid bits travel with the memory latency; the last stage is capture.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) lat_pipe <= '0;
        else      lat_pipe <= (lat_pipe << 1) | c_RD_LATENCY'(pop);
    end

    ipml_fifo_outbuf_ring #(
        .W     (c_RD_DATA_WIDTH),
        .DEPTH (c_BUF_DEPTH)
    ) u_ring (
        .clk     (rclk),
        .rst     (rrst),
        .wr_en   (capture),
        .wr_data (ram_rdata),
        .rd_en   (deq),
        .rd_data (dout),
        .level   (buf_level),
        .empty   (buf_empty),
        .full    (buf_full_unused)
    );

    assign dout_valid = !buf_empty;

endmodule

// File: tb/tb_ipml_fifo_fwft_rd_stage.sv
// Directed bench: instance A (latency 1, depth 2) and B (latency 3, depth 4),
// each fed by a small FIFO-controller/memory model.
module tb_ipml_fifo_fwft_rd_stage;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    logic fake_fill = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 rclk = ~rclk;

    // Instance A controller model
    logic       a_rempty, a_rd_en, a_valid;
    logic       a_ready = 1'b0;
    logic [7:0] a_rdata = 8'hEE;
    logic [7:0] a_dout;
    logic [2:0] a_level;
    logic [7:0] a_q [64];
    int         a_head = 0;
    int         a_tail = 0;

    assign a_rempty = (a_head == a_tail) && !fake_fill;

    always @(posedge rclk) begin
        if (a_rd_en && !a_rempty) begin
            a_rdata <= a_q[a_head];
            a_head  <= a_head + 1;
        end else begin
            a_rdata <= 8'hEE;
        end
    end

    // Instance B controller model, 3-cycle memory latency
    logic       b_rempty, b_rd_en, b_valid;
    logic       b_ready = 1'b0;
    logic [7:0] b_dl [3];
    logic [7:0] b_rdata;
    logic [7:0] b_dout;
    logic [2:0] b_level;
    logic [7:0] b_q [64];
    int         b_head = 0;
    int         b_tail = 0;

    assign b_rempty = (b_head == b_tail) && !fake_fill;
    assign b_rdata  = b_dl[2];

    always @(posedge rclk) begin
        if (b_rd_en && !b_rempty) begin
            b_dl[0] <= b_q[b_head];
            b_head  <= b_head + 1;
        end else begin
            b_dl[0] <= 8'hEE;
        end
        b_dl[1] <= b_dl[0];
        b_dl[2] <= b_dl[1];
    end

    ipml_fifo_fwft_rd_stage #(.c_RD_DATA_WIDTH(8), .c_RD_LATENCY(1), .c_BUF_DEPTH(2)) dut_a (
        .rclk(rclk), .rrst(rrst), .fifo_rempty(a_rempty), .fifo_rd_en(a_rd_en),
        .ram_rdata(a_rdata), .dout(a_dout), .dout_valid(a_valid),
        .dout_ready(a_ready), .buf_level(a_level)
    );

    ipml_fifo_fwft_rd_stage #(.c_RD_DATA_WIDTH(8), .c_RD_LATENCY(3), .c_BUF_DEPTH(4)) dut_b (
        .rclk(rclk), .rrst(rrst), .fifo_rempty(b_rempty), .fifo_rd_en(b_rd_en),
        .ram_rdata(b_rdata), .dout(b_dout), .dout_valid(b_valid),
        .dout_ready(b_ready), .buf_level(b_level)
    );

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            tests_run += 8;
            if (a_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_a_rd_en got %b want 0", a_rd_en); end
            if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_a_valid got %b want 0", a_valid); end
            if (a_dout !== 8'h00) begin tests_failed++; $display("FAIL reset_a_dout got %h want 00", a_dout); end
            if (a_level !== 3'd0) begin tests_failed++; $display("FAIL reset_a_level got %0d want 0", a_level); end
            if (b_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_b_rd_en got %b want 0", b_rd_en); end
            if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b_valid got %b want 0", b_valid); end
            if (b_dout !== 8'h00) begin tests_failed++; $display("FAIL reset_b_dout got %h want 00", b_dout); end
            if (b_level !== 3'd0) begin tests_failed++; $display("FAIL reset_b_level got %0d want 0", b_level); end
        end
        tick;
        rrst = 1'b0;
        fake_fill = 1'b0;
    endtask

    task automatic test_first_word;
        a_ready = 1'b0;
        a_q[a_tail] = 8'hA5; a_tail++;
        @(negedge rclk);
        tests_run++;
        if (a_rd_en !== 1'b1) begin tests_failed++; $display("FAIL first_rd_en got %b want 1", a_rd_en); end
        tick; @(negedge rclk);
        tests_run += 2;
        if (a_rdata !== 8'hA5) begin tests_failed++; $display("FAIL first_ram_rdata got %h want a5", a_rdata); end
        if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid got %b want 0", a_valid); end
        tick; @(negedge rclk);
        tests_run += 3;
        if (a_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid got %b want 1", a_valid); end
        if (a_dout !== 8'hA5) begin tests_failed++; $display("FAIL first_dout got %h want a5", a_dout); end
        if (a_level !== 3'd1) begin tests_failed++; $display("FAIL first_level got %0d want 1", a_level); end
        tick; @(negedge rclk);
        tests_run++;
        if (a_valid !== 1'b1 || a_dout !== 8'hA5) begin tests_failed++; $display("FAIL first_hold got %b/%h want 1/a5", a_valid, a_dout); end
        tick; a_ready = 1'b1;
        tick; @(negedge rclk);
        tests_run += 2;
        if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL first_drained_valid got %b want 0", a_valid); end
        if (a_level !== 3'd0) begin tests_failed++; $display("FAIL first_drained_level got %0d want 0", a_level); end
    endtask

    task automatic test_stream;
        int n = 0;
        tick;
        for (int i = 0; i < 16; i++) begin a_q[a_tail] = 8'(i); a_tail++; end
        a_ready = 1'b1;
        @(negedge rclk);
        while (!a_valid && n < 8) begin tick; @(negedge rclk); n++; end
        tests_run++;
        if (n !== 2) begin tests_failed++; $display("FAIL stream_latency got %0d want 2", n); end
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (a_valid !== 1'b1 || a_dout !== 8'(i)) begin
                tests_failed++; $display("FAIL stream_word%0d got %b/%h want 1/%h", i, a_valid, a_dout, 8'(i));
            end
            tick; @(negedge rclk);
        end
        tests_run++;
        if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_end_valid got %b want 0", a_valid); end
    endtask

    task automatic test_backpressure;
        int n = 0;
        tick;
        for (int i = 0; i < 12; i++) begin a_q[a_tail] = 8'(8'h40 + i); a_tail++; end
        a_ready = 1'b1;
        @(negedge rclk);
        while (!a_valid && n < 8) begin tick; @(negedge rclk); n++; end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (a_valid !== 1'b1 || a_dout !== 8'(8'h40 + i)) begin
                tests_failed++; $display("FAIL bp_pre%0d got %b/%h want 1/%h", i, a_valid, a_dout, 8'(8'h40 + i));
            end
            tick;
            if (i == 2) a_ready = 1'b0;
            @(negedge rclk);
        end
        for (int c = 0; c < 10; c++) begin
            tests_run += 2;
            if (a_valid !== 1'b1 || a_dout !== 8'h43) begin
                tests_failed++; $display("FAIL bp_hold%0d got %b/%h want 1/43", c, a_valid, a_dout);
            end
            if (a_level > 3'd2) begin tests_failed++; $display("FAIL bp_level%0d got %0d want <=2", c, a_level); end
            tick; @(negedge rclk);
        end
        tests_run += 2;
        if (a_level !== 3'd2) begin tests_failed++; $display("FAIL bp_sat_level got %0d want 2", a_level); end
        if (a_rd_en !== 1'b0) begin tests_failed++; $display("FAIL bp_sat_rd_en got %b want 0", a_rd_en); end
        tick; a_ready = 1'b1; @(negedge rclk);
        for (int i = 3; i < 12; i++) begin
            tests_run++;
            if (a_valid !== 1'b1 || a_dout !== 8'(8'h40 + i)) begin
                tests_failed++; $display("FAIL bp_post%0d got %b/%h want 1/%h", i, a_valid, a_dout, 8'(8'h40 + i));
            end
            tick; @(negedge rclk);
        end
        tests_run++;
        if (a_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_end_valid got %b want 0", a_valid); end
    endtask

    task automatic test_toggle_ready;
        int got = 0;
        int cyc = 0;
        tick;
        for (int i = 0; i < 32; i++) begin b_q[b_tail] = 8'(8'h80 + i); b_tail++; end
        b_ready = 1'b0;
        while (got < 32 && cyc < 300) begin
            tick;
            b_ready = ~b_ready;
            @(negedge rclk);
            tests_run++;
            if (b_level > 3'd4) begin tests_failed++; $display("FAIL toggle_level got %0d want <=4", b_level); end
            if (b_valid && b_ready) begin
                tests_run++;
                if (b_dout !== 8'(8'h80 + got)) begin
                    tests_failed++; $display("FAIL toggle_word%0d got %h want %h", got, b_dout, 8'(8'h80 + got));
                end
                got++;
            end
            cyc++;
        end
        tests_run++;
        if (got !== 32) begin tests_failed++; $display("FAIL toggle_count got %0d want 32", got); end
        tick; b_ready = 1'b0; @(negedge rclk);
        tests_run++;
        if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL toggle_end_valid got %b want 0", b_valid); end
    endtask

    task automatic test_mid_reset;
        tick;
        b_ready = 1'b0;
        b_q[b_tail] = 8'h31; b_tail++;
        b_q[b_tail] = 8'h32; b_tail++;
        b_q[b_tail] = 8'h33; b_tail++;
        @(negedge rclk);
        tests_run++;
        if (b_rd_en !== 1'b1) begin tests_failed++; $display("FAIL mid_rd_en got %b want 1", b_rd_en); end
        repeat (4) tick;
        @(negedge rclk);
        tests_run++;
        if (b_level !== 3'd1 || b_dout !== 8'h31) begin
            tests_failed++; $display("FAIL mid_pre_state got %0d/%h want 1/31", b_level, b_dout);
        end
        b_q[b_tail] = 8'h34; b_tail++;
        rrst = 1'b1;
        #1;
        tests_run += 4;
        if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid got %b want 0", b_valid); end
        if (b_level !== 3'd0) begin tests_failed++; $display("FAIL mid_rst_level got %0d want 0", b_level); end
        if (b_rd_en !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_rd_en got %b want 0", b_rd_en); end
        if (b_dout !== 8'h00) begin tests_failed++; $display("FAIL mid_rst_dout got %h want 00", b_dout); end
        b_tail = b_head;
        tick; tick;
        rrst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            tests_run++;
            if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_stale%0d got %b/%h want 0", c, b_valid, b_dout); end
            tick;
        end
        b_q[b_tail] = 8'h77; b_tail++;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            tests_run++;
            if (b_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_fresh_early%0d got %b want 0", c, b_valid); end
            tick;
        end
        @(negedge rclk);
        tests_run++;
        if (b_valid !== 1'b1 || b_dout !== 8'h77) begin
            tests_failed++; $display("FAIL mid_fresh got %b/%h want 1/77", b_valid, b_dout);
        end
    endtask

    initial begin
        test_reset;
        test_first_word;
        test_stream;
        test_backpressure;
        test_toggle_ready;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
